// File: rtl/alu_pkg.sv
// Shared types for the arbitrated ALU: FSM states, requester ID and the
// operation encoding understood by the alu sub-module.
package alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef logic req_id_t;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_ctrl_e;

endpackage

// File: rtl/alu.sv
// Combinational N-bit ALU; carry_out is bit N of the add/subtract result
// (borrow on SUB) and zero for the logic operations.
module alu
    import alu_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  alu_ctrl_e    ctrl,
    output logic [N-1:0] result,
    output logic         carry_out
);

    logic [N:0] wide;

    always_comb begin
        wide = '0;
        unique case (ctrl)
            ALU_ADD: wide = {1'b0, a} + {1'b0, b};
            ALU_SUB: wide = {1'b0, a} - {1'b0, b};
            ALU_AND: wide = {1'b0, a & b};
            ALU_OR:  wide = {1'b0, a | b};
            default: wide = '0;
        endcase
    end

    assign result    = wide[N-1:0];
    assign carry_out = wide[N];

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end sharing one alu: IDLE grants and
// captures a request, EXEC registers the alu output, RESP holds it until taken.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [1:0]   i_req_valid,
    output logic [1:0]   o_req_ready,
    input  logic [N-1:0] i_a0,
    input  logic [N-1:0] i_b0,
    input  logic [N-1:0] i_a1,
    input  logic [N-1:0] i_b1,
    input  logic [1:0]   i_alu_ctrl0,
    input  logic [1:0]   i_alu_ctrl1,
    output logic [1:0]   o_rsp_valid,
    input  logic [1:0]   i_rsp_ready,
    output logic [N-1:0] o_result,
    output logic         o_carry_out,
    output logic         o_busy
);

    state_e    state, nxt_state;
    req_id_t   last_id;
    req_id_t   grant_id;
    logic      grant_any;
    logic      req_hs;
    logic      rsp_done;

    logic [N-1:0] cap_a, cap_b;
    alu_ctrl_e    cap_ctrl;
    req_id_t      cap_id;

    logic [N-1:0] alu_result;
    logic         alu_carry;

    // With both valid, the requester not served last wins; a lone request always wins.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = 1'b0;
        unique case (i_req_valid)
            2'b01: begin grant_any = 1'b1; grant_id = 1'b0;     end
            2'b10: begin grant_any = 1'b1; grant_id = 1'b1;     end
            2'b11: begin grant_any = 1'b1; grant_id = ~last_id; end
            default: begin grant_any = 1'b0; grant_id = 1'b0;   end
        endcase
    end

    assign req_hs   = (state == ST_IDLE) && grant_any && i_rst_n;
    assign rsp_done = (state == ST_RESP) && i_rsp_ready[cap_id];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= ST_IDLE;
            last_id <= 1'b1;
        end else begin
            state <= nxt_state;
            if (req_hs)
                last_id <= grant_id;
        end
    end

    always_comb begin
        nxt_state   = state;
        o_req_ready = 2'b00;
        o_rsp_valid = 2'b00;
        o_busy      = 1'b1;
        unique case (state)
            ST_IDLE: begin
                o_busy = 1'b0;
                if (grant_any && i_rst_n)
                    o_req_ready = grant_id ? 2'b10 : 2'b01;
                if (req_hs)
                    nxt_state = ST_EXEC;
            end
            ST_EXEC: nxt_state = ST_RESP;
            ST_RESP: begin
                o_rsp_valid = cap_id ? 2'b10 : 2'b01;
                if (rsp_done)
                    nxt_state = ST_IDLE;
            end
            default: nxt_state = ST_IDLE;
        endcase
    end

    // Operand capture is pure data; only the handshake qualifies it.
    always_ff @(posedge i_clk) begin
        if (req_hs) begin
            cap_id   <= grant_id;
            cap_a    <= grant_id ? i_a1 : i_a0;
            cap_b    <= grant_id ? i_b1 : i_b0;
            cap_ctrl <= alu_ctrl_e'(grant_id ? i_alu_ctrl1 : i_alu_ctrl0);
        end
    end

    alu #(.N(N)) u_alu (
        .a         (cap_a),
        .b         (cap_b),
        .ctrl      (cap_ctrl),
        .result    (alu_result),
        .carry_out (alu_carry)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_result    <= '0;
            o_carry_out <= 1'b0;
        end else if (state == ST_EXEC) begin
            o_result    <= alu_result;
            o_carry_out <= alu_carry;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed scoreboard bench for alu_arbiter: expectations are queued at each
// request handshake and compared when the matching response appears.
module tb_alu_arbiter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [N-1:0] a0, b0, a1, b1;
    logic [1:0]   ctrl0, ctrl1;
    logic [1:0]   rsp_valid;
    logic [1:0]   rsp_ready;
    logic [N-1:0] result;
    logic         carry;
    logic         busy;

    typedef struct packed {
        logic         id;
        logic [N-1:0] res;
        logic         cy;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.N(N)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_a0        (a0),
        .i_b0        (b0),
        .i_a1        (a1),
        .i_b1        (b1),
        .i_alu_ctrl0 (ctrl0),
        .i_alu_ctrl1 (ctrl1),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_result    (result),
        .o_carry_out (carry),
        .o_busy      (busy)
    );

    function automatic logic [N:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic [1:0] op);
        case (op)
            2'b00:   return {1'b0, a} + {1'b0, b};
            2'b01:   return {1'b0, a} - {1'b0, b};
            2'b10:   return {1'b0, a & b};
            default: return {1'b0, a | b};
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits for a request handshake, checks who got it, queues the expectation.
    task automatic wait_grant(input int want_id);
        int   got;
        exp_t e;
        logic [N:0] m;
        got = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((req_ready & req_valid) != 2'b00) begin
                got = req_ready[1] ? 1 : 0;
                break;
            end
        end
        if (got < 0) begin
            check("grant_timeout", 32'd1, 32'd0);
        end else begin
            check("req_ready_grant", {30'd0, req_ready}, (want_id == 1) ? 32'd2 : 32'd1);
            m     = (got == 1) ? model(a1, b1, ctrl1) : model(a0, b0, ctrl0);
            e.id  = (got == 1);
            e.res = m[N-1:0];
            e.cy  = m[N];
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    // Called right after a handshake: response must show up on the second negedge.
    task automatic wait_rsp(input string tag);
        int   n;
        exp_t e;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n++;
            if (rsp_valid != 2'b00) break;
        end
        if (rsp_valid == 2'b00 || sb.size() == 0) begin
            check({tag, "_rsp_timeout"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({tag, "_latency"}, n, 32'd2);
            check({tag, "_rsp_valid"}, {30'd0, rsp_valid}, e.id ? 32'd2 : 32'd1);
            check({tag, "_result"}, {28'd0, result}, {28'd0, e.res});
            check({tag, "_carry"}, {31'd0, carry}, {31'd0, e.cy});
        end
    endtask

    task automatic finish_rsp();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [N-1:0] held;
        rst_n     = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        ctrl0 = 2'b00; ctrl1 = 2'b00;

        #1;
        check("rst_req_ready", {30'd0, req_ready}, 32'd0);
        check("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check("rst_result", {28'd0, result}, 32'd0);
        check("rst_carry", {31'd0, carry}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        req_valid = 2'b00;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single request on 0: 3 + 5
        a0 = 4'd3; b0 = 4'd5; ctrl0 = 2'b00; req_valid = 2'b01;
        wait_grant(0);
        req_valid = 2'b00;
        check("exec_busy", {31'd0, busy}, 32'd1);
        wait_rsp("single");
        finish_rsp();

        // Carry on requester 1: F + 1
        a1 = 4'hF; b1 = 4'h1; ctrl1 = 2'b00; req_valid = 2'b10;
        wait_grant(1);
        req_valid = 2'b00;
        wait_rsp("carry");
        finish_rsp();

        // Reset while in EXEC discards the operation
        a0 = 4'd9; b0 = 4'd4; ctrl0 = 2'b01; req_valid = 2'b01;
        wait_grant(0);
        rst_n = 1'b0;
        #1;
        void'(sb.pop_front());
        check("midrst_result", {28'd0, result}, 32'd0);
        check("midrst_carry", {31'd0, carry}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_req_ready", {30'd0, req_ready}, 32'd0);
        check("midrst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        req_valid = 2'b00;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("midrst_no_rsp", {30'd0, rsp_valid}, 32'd0);
        end
        @(posedge clk);
        #1;

        // Contention right after reset: 0,1,0,1
        a0 = 4'd2; b0 = 4'd7; ctrl0 = 2'b01;
        a1 = 4'hC; b1 = 4'hA; ctrl1 = 2'b10;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_grant(k % 2);
            wait_rsp("contend");
            finish_rsp();
        end
        req_valid = 2'b00;

        // Backpressure with requester 1 waiting and operands changed after handshake
        a0 = 4'd6; b0 = 4'd3; ctrl0 = 2'b11;
        a1 = 4'd5; b1 = 4'd5; ctrl1 = 2'b01;
        rsp_ready = 2'b00;
        req_valid = 2'b01;
        wait_grant(0);
        req_valid = 2'b10;
        a0 = 4'hE; b0 = 4'hE; ctrl0 = 2'b00;
        wait_rsp("bp");
        held = result;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_result_stable", {28'd0, result}, {28'd0, held});
            check("bp_req_ready", {30'd0, req_ready}, 32'd0);
            check("bp_rsp_valid", {30'd0, rsp_valid}, 32'd1);
        end
        rsp_ready = 2'b11;
        finish_rsp();
        wait_grant(1);
        req_valid = 2'b00;
        wait_rsp("bp_waiter");
        finish_rsp();

        // Ready from the wrong requester is ignored
        a0 = 4'd8; b0 = 4'd1; ctrl0 = 2'b11;
        rsp_ready = 2'b10;
        req_valid = 2'b01;
        wait_grant(0);
        req_valid = 2'b00;
        wait_rsp("wrongid");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("wrongid_hold", {30'd0, rsp_valid}, 32'd1);
            check("wrongid_busy", {31'd0, busy}, 32'd1);
        end
        rsp_ready = 2'b01;
        finish_rsp();
        @(negedge clk);
        check("wrongid_done_busy", {31'd0, busy}, 32'd0);
        check("wrongid_done_rsp", {30'd0, rsp_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter N, default 4, giving the operand/result width of the shared alu.
REQ-002 SHALL have port i_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port i_req_valid, input, 2, per-requester request valid (index 0/1).
REQ-005 SHALL have port o_req_ready, output, 2, per-requester request accept.
REQ-006 SHALL have ports i_a0/i_b0 and i_a1/i_b1, input, N each, operands of requester 0/1.
REQ-007 SHALL have ports i_alu_ctrl0/i_alu_ctrl1, input, 2 each, operation of requester 0/1.
REQ-008 SHALL have port o_rsp_valid, output, 2, one-hot response valid, addressed to the owning requester.
REQ-009 SHALL have port i_rsp_ready, input, 2, per-requester response accept.
REQ-010 SHALL have ports o_result (output, N) and o_carry_out (output, 1), the registered alu outputs of the current response.
REQ-011 SHALL have port o_busy, output, 1, high in any state other than IDLE.

Function
REQ-012 SHALL implement an FSM with states IDLE, EXEC, RESP.
REQ-013 IDLE: o_req_ready SHALL be high only for the granted requester; none are granted when i_req_valid is 2'b00.
REQ-014 Arbitration SHALL be round-robin: if both are valid, grant goes to the requester not served last; if one is valid, it is granted regardless of history.
REQ-015 On a handshake (valid and ready both high) SHALL capture that requester's operands, ctrl and ID, and go to EXEC.
REQ-016 EXEC: SHALL drive the captured operands into the alu and register o_result/o_carry_out; this lasts exactly one cycle, then RESP.
REQ-017 RESP: o_rsp_valid SHALL be one-hot on the captured ID; o_result/o_carry_out SHALL stay stable until i_rsp_ready of that ID is high, then IDLE.
REQ-018 Latency SHALL be: request handshake in cycle t, o_rsp_valid high from cycle t+2.
REQ-019 i_rsp_ready of the non-owning requester SHALL be ignored.
REQ-020 o_req_ready SHALL be 2'b00 in EXEC and RESP; requests held valid there SHALL wait without being lost.
REQ-021 The last-served pointer SHALL update only on a request handshake.
REQ-022 Input changes after the handshake SHALL NOT affect the in-flight result.
REQ-023 The alu carry out SHALL be passed through unchanged; no width extension of o_result.
REQ-024 Throughput SHALL be at most one operation per 3 cycles; back-to-back requests SHALL alternate strictly when both stay valid.

Reset
REQ-025 When i_rst_n is low, the FSM SHALL go to IDLE immediately, with o_req_ready=2'b00, o_rsp_valid=2'b00, o_result=0, o_carry_out=0, o_busy=0.
REQ-026 After reset the last-served pointer SHALL be 1, so requester 0 wins the first contested arbitration.
REQ-027 Reset during EXEC or RESP SHALL discard the in-flight operation, with no response issued afterwards.
REQ-028 o_req_ready SHALL be allowed to rise on the first clock edge after i_rst_n deasserts.

Structure
REQ-029 A shared package alu_pkg SHALL hold the FSM state enum, the requester-ID type, and the alu_ctrl encoding: 00 ADD, 01 SUB, 10 AND, 11 OR.
REQ-030 The block SHALL instantiate the existing alu sub-module once, with N passed through; no second arithmetic path is allowed.
REQ-031 Arbitration logic SHALL stay inline; no further sub-modules.

Verification
REQ-032 Single request: req0 with a=3, b=5, ADD; rsp_ready held 1 -> o_rsp_valid=2'b01 at t+2, result=8, carry=0.
REQ-033 Carry: req1 with a=4'hF, b=4'h1, ADD -> o_rsp_valid=2'b10, result=0, carry=1.
REQ-034 Contention after reset: both requests valid and held -> grant order 0,1,0,1 over four operations.
REQ-035 Backpressure: i_rsp_ready=0 for 5 cycles in RESP -> result is stable, o_req_ready=2'b00 throughout, and the response completes once ready=1.
REQ-036 Reset mid-operation: i_rst_n pulled low in EXEC -> outputs are zero immediately, and no o_rsp_valid follows.
REQ-037 Wrong-ID ready: in RESP for ID 0, i_rsp_ready=2'b10 -> the FSM stays in RESP.
